udp_rx_frame_assembler: RTL and testbench

//   Receive-side stage between the udp core's header/byte outputs and the RIO rx_data register.
//   - Consumes one UDP datagram's header words and payload bytes.
//   - Filters packets on destination port.
//   - Checks payload length and the MSGID word.
//   - On success, atomically latches the payload plus sender IP/port, pulses rx_valid_o and rearms the link watchdog.

---
 rtl/udp_rx_frame_assembler.sv | 180 ++++++++++++++++++
 tb/tb_udp_rx_frame_assembler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_frame_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : udp_rx_frame_assembler
// Purpose  : Assembles one UDP datagram (header words + payload bytes),
//            filters on destination port, checks length and MSGID, and on
//            success latches payload/sender info and rearms a link watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module udp_rx_frame_assembler #(
  parameter int          BUFFER_SIZE = 80,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter logic [15:0] UDP_PORT    = 16'd2390,
  parameter logic [31:0] TIMEOUT     = 32'd4800000
) (
  input  logic                   clk50m,
  input  logic                   rst,
  input  logic                   head_av_i,
  output logic                   head_rdy_o,
  input  logic [31:0]            head_i,
  input  logic                   data_av_i,
  input  logic [7:0]             data_i,
  output logic [BUFFER_SIZE-1:0] rx_data_o,
  output logic                   rx_valid_o,
  output logic [31:0]            src_ip_o,
  output logic [15:0]            src_port_o,
  output logic                   pkg_timeout_o,
  output logic [7:0]             err_count_o
);

  localparam logic [7:0] c_nbytes = 8'(BUFFER_SIZE / 8);
  localparam logic [7:0] c_wait_max = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_IP   = 3'd1,
    HDR_SKIP = 3'd2,
    HDR_PORT = 3'd3,
    PAYLOAD  = 3'd4,
    CHECK    = 3'd5,
    DISCARD  = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [BUFFER_SIZE-1:0] r_shift;
  logic [7:0]             r_cnt;
  logic [7:0]             r_wait;
  logic                   r_seen;
  logic [31:0]            r_ip_sh;
  logic [15:0]            r_port_sh;
  logic [31:0]            r_wdog;
  logic [31:0]            w_wdog_nxt;
  logic                   w_frame_ok;
  logic                   w_err_inc;
  logic                   w_head_rdy;

  // State register.
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic, header handshake, frame verdict and error strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_head_rdy  = 1'b0;
    w_frame_ok  = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (head_av_i) begin
          w_head_rdy  = 1'b1;
          w_state_nxt = HDR_IP;
        end
      end
      HDR_IP:   w_state_nxt = HDR_SKIP;
      HDR_SKIP: w_state_nxt = HDR_PORT;
      HDR_PORT: w_state_nxt = (head_i[15:0] == UDP_PORT) ? PAYLOAD : DISCARD;
      PAYLOAD: begin
        if (!data_av_i) begin
          if (r_cnt != 8'd0) begin
            w_state_nxt = CHECK;
          end else if (r_wait == c_wait_max) begin
            w_err_inc   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      CHECK: begin
        w_frame_ok  = (r_cnt == c_nbytes) &&
                      (r_shift[BUFFER_SIZE-1:BUFFER_SIZE-32] == MSGID);
        w_err_inc   = !w_frame_ok;
        w_state_nxt = IDLE;
      end
      DISCARD: begin
        if (!data_av_i && (r_seen || r_wait == c_wait_max)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Clear on a good frame beats the count-up.
    if (w_frame_ok)             w_wdog_nxt = 32'd0;
    else if (r_wdog < TIMEOUT)  w_wdog_nxt = r_wdog + 32'd1;
    else                        w_wdog_nxt = r_wdog;
  end

  assign head_rdy_o = w_head_rdy;

  // Payload shifting, byte count, idle-wait counter and header shadows.
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_cnt     <= 8'd0;
      r_wait    <= 8'd0;
      r_seen    <= 1'b0;
      r_ip_sh   <= 32'd0;
      r_port_sh <= 16'd0;
    end else begin
      case (r_state)
        HDR_IP: r_ip_sh <= head_i;
        HDR_PORT: begin
          r_port_sh <= head_i[31:16];
          r_shift   <= '0;
          r_cnt     <= 8'd0;
          r_wait    <= 8'd0;
          r_seen    <= 1'b0;
        end
        PAYLOAD: begin
          if (data_av_i) begin
            r_shift <= {r_shift[BUFFER_SIZE-9:0], data_i};
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          end else if (r_wait != c_wait_max) begin
            r_wait <= r_wait + 8'd1;
          end
        end
        DISCARD: begin
          if (data_av_i) begin
            r_seen <= 1'b1;
            r_wait <= 8'd0;
          end else if (r_wait != c_wait_max) begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output latch on a good frame, saturating reject counter.
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      rx_data_o   <= '0;
      src_ip_o    <= 32'd0;
      src_port_o  <= 16'd0;
      rx_valid_o  <= 1'b0;
      err_count_o <= 8'd0;
    end else begin
      rx_valid_o <= w_frame_ok;
      if (w_frame_ok) begin
        rx_data_o  <= r_shift;
        src_ip_o   <= r_ip_sh;
        src_port_o <= r_port_sh;
      end
      if (w_err_inc && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
    end
  end

  // Link watchdog and its registered timeout flag.
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_wdog        <= TIMEOUT;
      pkg_timeout_o <= 1'b1;
    end else begin
      r_wdog        <= w_wdog_nxt;
      pkg_timeout_o <= (w_wdog_nxt >= TIMEOUT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_frame_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_udp_rx_frame_assembler
// Purpose  : Directed self-checking bench for udp_rx_frame_assembler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_rx_frame_assembler;

  logic        clk50m = 1'b0;
  logic        rst;
  logic        head_av_i;
  logic        head_rdy_o;
  logic [31:0] head_i;
  logic        data_av_i;
  logic [7:0]  data_i;
  logic [79:0] rx_data_o;
  logic        rx_valid_o;
  logic [31:0] src_ip_o;
  logic [15:0] src_port_o;
  logic        pkg_timeout_o;
  logic [7:0]  err_count_o;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic [7:0] pl [0:15];

  udp_rx_frame_assembler #(
    .BUFFER_SIZE (80),
    .MSGID       (32'h74697277),
    .UDP_PORT    (16'd2390),
    .TIMEOUT     (32'd100)
  ) dut (
    .clk50m        (clk50m),
    .rst           (rst),
    .head_av_i     (head_av_i),
    .head_rdy_o    (head_rdy_o),
    .head_i        (head_i),
    .data_av_i     (data_av_i),
    .data_i        (data_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .src_ip_o      (src_ip_o),
    .src_port_o    (src_port_o),
    .pkg_timeout_o (pkg_timeout_o),
    .err_count_o   (err_count_o)
  );

  always #10 clk50m = ~clk50m;

  // Count every rx_valid_o pulse, sampled just after the edge.
  always @(posedge clk50m) begin
    #1;
    if (rx_valid_o === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50m);
      #1;
    end
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sport,
                          input logic [15:0] dport, input string tag);
    head_av_i = 1'b1;
    #1;
    chk({tag, " head_rdy"}, 128'(head_rdy_o), 128'd1);
    tick(1);
    head_av_i = 1'b0;
    head_i = ip;
    tick(1);
    head_i = 32'hDEADBEEF;
    tick(1);
    head_i = {sport, dport};
    tick(1);
    head_i = 32'd0;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      data_av_i = 1'b1;
      data_i = pl[i];
      tick(1);
    end
    data_av_i = 1'b0;
    data_i = 8'd0;
  endtask

  task automatic send_pkt(input logic [31:0] ip, input logic [15:0] sport,
                          input logic [15:0] dport, input int n,
                          input logic exp_valid, input string tag);
    send_hdr(ip, sport, dport, tag);
    send_bytes(n);
    tick(1);
    chk({tag, " valid_e1"}, 128'(rx_valid_o), 128'd0);
    tick(1);
    chk({tag, " valid_e2"}, 128'(rx_valid_o), 128'(exp_valid));
  endtask

  task automatic load_good1();
    pl[0] = 8'h74; pl[1] = 8'h69; pl[2] = 8'h72; pl[3] = 8'h77;
    for (int i = 4; i < 16; i++) pl[i] = 8'(i - 3);
  endtask

  initial begin
    rst = 1'b0; head_av_i = 1'b0; head_i = 32'd0; data_av_i = 1'b0; data_i = 8'd0;
    load_good1();

    // 1. Reset and no traffic
    tick(3);
    chk("rst timeout", 128'(pkg_timeout_o), 128'd1);
    chk("rst rx_data", 128'(rx_data_o), 128'd0);
    chk("rst err", 128'(err_count_o), 128'd0);
    chk("rst src_ip", 128'(src_ip_o), 128'd0);
    chk("rst rx_valid", 128'(rx_valid_o), 128'd0);
    chk("rst head_rdy", 128'(head_rdy_o), 128'd0);
    rst = 1'b1;
    tick(100);
    chk("idle timeout", 128'(pkg_timeout_o), 128'd1);

    // 2. Good packet
    send_pkt(32'hC0A80A01, 16'd1234, 16'd2390, 10, 1'b1, "good1");
    chk("good1 data", 128'(rx_data_o), 128'(80'h74697277010203040506));
    chk("good1 ip", 128'(src_ip_o), 128'h C0A80A01);
    chk("good1 port", 128'(src_port_o), 128'd1234);
    chk("good1 timeout", 128'(pkg_timeout_o), 128'd0);
    tick(2);
    chk("good1 pulses", 128'(pulses), 128'd1);

    // 3. Wrong destination port
    send_pkt(32'h0B0B0B0B, 16'd999, 16'd2391, 10, 1'b0, "badport");
    chk("badport data", 128'(rx_data_o), 128'(80'h74697277010203040506));
    chk("badport ip", 128'(src_ip_o), 128'h C0A80A01);
    chk("badport err", 128'(err_count_o), 128'd0);

    // 4. Short, long and wrong-MSGID packets, then a good one
    send_pkt(32'h01010101, 16'd1, 16'd2390, 9, 1'b0, "short");
    chk("short err", 128'(err_count_o), 128'd1);
    send_pkt(32'h01010101, 16'd1, 16'd2390, 11, 1'b0, "long");
    chk("long err", 128'(err_count_o), 128'd2);
    pl[3] = 8'h78;
    send_pkt(32'h01010101, 16'd1, 16'd2390, 10, 1'b0, "msgid");
    chk("msgid err", 128'(err_count_o), 128'd3);
    chk("msgid data", 128'(rx_data_o), 128'(80'h74697277010203040506));
    pl[3] = 8'h77; pl[4] = 8'hAA; pl[5] = 8'hBB; pl[6] = 8'hCC;
    pl[7] = 8'hDD; pl[8] = 8'hEE; pl[9] = 8'hFF;
    send_pkt(32'h0A000002, 16'd5555, 16'd2390, 10, 1'b1, "good2");
    chk("good2 data", 128'(rx_data_o), 128'(80'h74697277AABBCCDDEEFF));
    chk("good2 ip", 128'(src_ip_o), 128'h0A000002);
    chk("good2 port", 128'(src_port_o), 128'd5555);
    chk("good2 err", 128'(err_count_o), 128'd3);
    chk("good2 pulses", 128'(pulses), 128'd2);

    // 5. Watchdog expiry after a valid frame
    load_good1();
    send_pkt(32'hC0A80A01, 16'd1234, 16'd2390, 10, 1'b1, "wd1");
    chk("wd1 timeout", 128'(pkg_timeout_o), 128'd0);
    tick(99);
    chk("wd 99 cycles", 128'(pkg_timeout_o), 128'd0);
    tick(1);
    chk("wd 100 cycles", 128'(pkg_timeout_o), 128'd1);
    send_pkt(32'hC0A80A01, 16'd1234, 16'd2390, 10, 1'b1, "wd2");
    chk("wd2 timeout", 128'(pkg_timeout_o), 128'd0);

    // 6. Reset mid-payload, then a good packet
    send_hdr(32'h0C0C0C0C, 16'd77, 16'd2390, "mid");
    for (int i = 0; i < 4; i++) begin
      data_av_i = 1'b1;
      data_i = pl[i];
      tick(1);
    end
    rst = 1'b0;
    #1;
    chk("mid rst data", 128'(rx_data_o), 128'd0);
    chk("mid rst ip", 128'(src_ip_o), 128'd0);
    chk("mid rst port", 128'(src_port_o), 128'd0);
    chk("mid rst err", 128'(err_count_o), 128'd0);
    chk("mid rst timeout", 128'(pkg_timeout_o), 128'd1);
    data_av_i = 1'b0;
    data_i = 8'd0;
    tick(2);
    rst = 1'b1;
    tick(1);
    send_pkt(32'hC0A80A09, 16'd4321, 16'd2390, 10, 1'b1, "post");
    chk("post data", 128'(rx_data_o), 128'(80'h74697277010203040506));
    chk("post ip", 128'(src_ip_o), 128'hC0A80A09);
    chk("post port", 128'(src_port_o), 128'd4321);
    chk("post err", 128'(err_count_o), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
